// File: rtl/mdc_pkg.sv
// Shared types and defaults for the MDC clock generator and its reset sequencer.
// Combinational only: no latency, no backpressure.
package mdc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_STOPPING = 2'd2
  } mdc_state_e;

  localparam int MDC_DIV_DEFAULT = 50;
  localparam int MDC_RST_HOLD    = 4;

endpackage

// File: rtl/mdc_rst_seq.sv
// Holds div_rst for RST_HOLD MDC rising edges after reset or soft_rst; registered output.
// soft_rst asserts div_rst one cycle later; release coincides with the final rise; no backpressure.
module mdc_rst_seq
  import mdc_pkg::*;
#(
  parameter int RST_HOLD = MDC_RST_HOLD
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rise_evt,
  input  logic soft_rst,
  output logic div_rst
);

  localparam int HOLD_W = $clog2(RST_HOLD + 1);

  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              rst_q, rst_d;

  always_comb begin
    hold_d = hold_q;
    rst_d  = rst_q;
    // A soft reset landing on the final rise restarts the sequence.
    if (soft_rst) begin
      rst_d  = 1'b1;
      hold_d = '0;
    end else if (rst_q && rise_evt) begin
      hold_d = hold_q + HOLD_W'(1);
      if (hold_q == HOLD_W'(RST_HOLD - 1)) begin
        rst_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
      rst_q  <= 1'b1;
    end else begin
      hold_q <= hold_d;
      rst_q  <= rst_d;
    end
  end

  assign div_rst = rst_q;

endmodule

// File: rtl/mdc_clk_gen.sv
// MDC clock divider with glitch-free start/stop, rise/fall strobes and sequenced Div_Rst.
// Strobes registered with MDC_Clk (zero latency to the transition); no backpressure.
module mdc_clk_gen
  import mdc_pkg::*;
#(
  parameter int DIV_W       = 8,
  parameter int DIV_DEFAULT = MDC_DIV_DEFAULT,
  parameter int RST_HOLD    = MDC_RST_HOLD
) (
  input  logic             AXI_Clk,
  input  logic             AXI_Rstn,
  input  logic [DIV_W-1:0] Div_Half,
  input  logic             Div_Load,
  input  logic             Clk_En,
  input  logic             Soft_Rst,
  output logic             MDC_Clk,
  output logic             MDC_Rise,
  output logic             MDC_Fall,
  output logic             MDC_Active,
  output logic             Div_Rst,
  output logic             Div_Err
);

  mdc_state_e       state_q, state_d;
  logic [DIV_W-1:0] half_q, half_d;
  logic [DIV_W-1:0] pend_q, pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             mdc_q, mdc_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             err_q, err_d;

  logic tick, rise_evt, stop, at_rest, div_rst;

  always_comb begin
    tick     = (state_q != ST_IDLE) && (cnt_q == half_q - DIV_W'(1));
    rise_evt = tick && !mdc_q;
    stop     = !Clk_En && !div_rst;
    at_rest  = mdc_q && (cnt_q == '0);
  end

  // at_rest: clock has just risen, so parking here leaves no runt pulse.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (!stop) state_d = ST_RUN;
      ST_RUN:      if (stop) state_d = at_rest ? ST_IDLE : ST_STOPPING;
      ST_STOPPING: begin
        if (!stop)         state_d = ST_RUN;
        else if (rise_evt) state_d = ST_IDLE;
      end
      default:     state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_d  = cnt_q;
    mdc_d  = mdc_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (state_q != ST_IDLE) begin
      if (tick) begin
        cnt_d  = '0;
        mdc_d  = !mdc_q;
        rise_d = !mdc_q;
        fall_d = mdc_q;
      end else begin
        cnt_d = cnt_q + DIV_W'(1);
      end
    end
    if (state_d == ST_IDLE) begin
      cnt_d  = '0;
      mdc_d  = 1'b1;
      fall_d = 1'b0;
    end
  end

  // New divisor takes effect only at a period boundary (or immediately when parked).
  always_comb begin
    half_d     = half_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    err_d      = 1'b0;
    if (pend_vld_q && (state_q == ST_IDLE || rise_evt)) begin
      half_d     = pend_q;
      pend_vld_d = 1'b0;
    end
    if (Div_Load) begin
      if (Div_Half == '0) begin
        err_d = 1'b1;
      end else begin
        pend_d     = Div_Half;
        pend_vld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge AXI_Clk or negedge AXI_Rstn) begin
    if (!AXI_Rstn) begin
      state_q    <= ST_IDLE;
      half_q     <= DIV_W'(DIV_DEFAULT);
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      cnt_q      <= '0;
      mdc_q      <= 1'b1;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      half_q     <= half_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      cnt_q      <= cnt_d;
      mdc_q      <= mdc_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      err_q      <= err_d;
    end
  end

  mdc_rst_seq #(
    .RST_HOLD (RST_HOLD)
  ) u_rst_seq (
    .clk      (AXI_Clk),
    .rst_n    (AXI_Rstn),
    .rise_evt (rise_evt),
    .soft_rst (Soft_Rst),
    .div_rst  (div_rst)
  );

  assign MDC_Clk    = mdc_q;
  assign MDC_Rise   = rise_q;
  assign MDC_Fall   = fall_q;
  assign MDC_Active = (state_q != ST_IDLE);
  assign Div_Rst    = div_rst;
  assign Div_Err    = err_q;

endmodule

// File: tb/tb_mdc_clk_gen.sv
// Scoreboard bench for mdc_clk_gen: expected strobe events are queued with their cycle,
// a negedge monitor pops and compares every strobe the DUT produces.
module tb_mdc_clk_gen;

  logic       AXI_Clk = 1'b0;
  logic       AXI_Rstn = 1'b0;
  logic [7:0] Div_Half = '0;
  logic       Div_Load = 1'b0;
  logic       Clk_En = 1'b0;
  logic       Soft_Rst = 1'b0;
  logic       MDC_Clk, MDC_Rise, MDC_Fall, MDC_Active, Div_Rst, Div_Err;

  mdc_clk_gen #(
    .DIV_W       (8),
    .DIV_DEFAULT (50),
    .RST_HOLD    (4)
  ) dut (
    .AXI_Clk    (AXI_Clk),
    .AXI_Rstn   (AXI_Rstn),
    .Div_Half   (Div_Half),
    .Div_Load   (Div_Load),
    .Clk_En     (Clk_En),
    .Soft_Rst   (Soft_Rst),
    .MDC_Clk    (MDC_Clk),
    .MDC_Rise   (MDC_Rise),
    .MDC_Fall   (MDC_Fall),
    .MDC_Active (MDC_Active),
    .Div_Rst    (Div_Rst),
    .Div_Err    (Div_Err)
  );

  always #5 AXI_Clk = ~AXI_Clk;

  int cyc = 0;
  always @(posedge AXI_Clk) cyc <= cyc + 1;

  localparam int K_RISE = 0;
  localparam int K_FALL = 1;
  localparam int K_ERR  = 2;
  localparam int K_RSTF = 3;

  typedef struct {
    int kind;
    int at;
  } evt_t;

  evt_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  logic prev_rst = 1'b1;

  function automatic string kname(input int k);
    case (k)
      K_RISE:  return "rise";
      K_FALL:  return "fall";
      K_ERR:   return "div_err";
      default: return "div_rst_fall";
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int kind, input int at);
    evt_t e;
    e.kind = kind;
    e.at   = at;
    exp_q.push_back(e);
  endtask

  // n alternating edges of a running clock that was high at cycle base: fall first.
  task automatic push_run(input int base, input int h, input int n);
    for (int k = 1; k <= n; k++) begin
      push((k % 2 == 1) ? K_FALL : K_RISE, base + k * h);
    end
  endtask

  task automatic seen(input int kind);
    evt_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_errors++;
      $display("FAIL event: got %s at cycle %0d, expected none", kname(kind), cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.at != cyc) begin
        n_errors++;
        $display("FAIL event: got %s at cycle %0d, expected %s at cycle %0d",
                 kname(kind), cyc, kname(e.kind), e.at);
      end
    end
  endtask

  always @(negedge AXI_Clk) begin
    if (MDC_Rise) seen(K_RISE);
    if (MDC_Fall) seen(K_FALL);
    if (Div_Err) seen(K_ERR);
    if (prev_rst && !Div_Rst) seen(K_RSTF);
    prev_rst <= Div_Rst;
  end

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge AXI_Clk);
  endtask

  task automatic load(input logic [7:0] v);
    Div_Half = v;
    Div_Load = 1'b1;
    @(negedge AXI_Clk);
    Div_Load = 1'b0;
  endtask

  int e1, e2, e3, e4;

  initial begin
    repeat (3) @(negedge AXI_Clk);
    chk("rst_mdc_clk", MDC_Clk, 1);
    chk("rst_rise", MDC_Rise, 0);
    chk("rst_fall", MDC_Fall, 0);
    chk("rst_active", MDC_Active, 0);
    chk("rst_div_rst", Div_Rst, 1);
    chk("rst_div_err", Div_Err, 0);

    // Release with Clk_En low: reset sequence runs four default periods then parks.
    AXI_Rstn = 1'b1;
    e1 = cyc + 1;
    push_run(e1, 50, 8);
    push(K_RSTF, e1 + 400);
    wait_cyc(e1 + 400);
    chk("active_at_final_rise", MDC_Active, 1);
    wait_cyc(e1 + 401);
    chk("active_after_release", MDC_Active, 0);
    chk("mdc_parked_high", MDC_Clk, 1);
    chk("div_rst_released", Div_Rst, 0);

    // Run, bad load, divisor 10 mid-low-phase, back to 50, then stop in a low phase.
    wait_cyc(e1 + 410);
    Clk_En = 1'b1;
    e2 = cyc + 1;
    push(K_ERR, e2 + 21);
    push_run(e2, 50, 2);
    push_run(e2 + 100, 10, 4);
    push_run(e2 + 140, 50, 4);
    wait_cyc(e2 + 20);
    load(8'd0);
    wait_cyc(e2 + 70);
    chk("low_phase_h50", MDC_Clk, 0);
    load(8'd10);
    wait_cyc(e2 + 125);
    load(8'd50);
    wait_cyc(e2 + 300);
    chk("low_before_stop", MDC_Clk, 0);
    Clk_En = 1'b0;
    wait_cyc(e2 + 420);
    chk("stopped_high", MDC_Clk, 1);
    chk("stopped_inactive", MDC_Active, 0);
    chk("events_drained_stop", exp_q.size(), 0);

    // Soft reset while running: clock continues, Div_Rst held for four more rises.
    Clk_En = 1'b1;
    e3 = cyc + 1;
    push_run(e3, 50, 10);
    push(K_RSTF, e3 + 500);
    wait_cyc(e3 + 120);
    chk("div_rst_before_soft", Div_Rst, 0);
    Soft_Rst = 1'b1;
    @(negedge AXI_Clk);
    Soft_Rst = 1'b0;
    chk("div_rst_after_soft", Div_Rst, 1);
    chk("mdc_uninterrupted", MDC_Clk, 1);
    wait_cyc(e3 + 499);
    chk("div_rst_before_4th", Div_Rst, 1);
    wait_cyc(e3 + 500);
    chk("div_rst_at_4th", Div_Rst, 0);

    // Pending load then asynchronous reset mid-high-phase.
    wait_cyc(e3 + 510);
    load(8'd10);
    wait_cyc(e3 + 520);
    chk("events_drained_soft", exp_q.size(), 0);
    chk("active_before_arst", MDC_Active, 1);
    #2 AXI_Rstn = 1'b0;
    #1;
    chk("arst_mdc_clk", MDC_Clk, 1);
    chk("arst_div_rst", Div_Rst, 1);
    chk("arst_active", MDC_Active, 0);
    chk("arst_rise", MDC_Rise, 0);
    chk("arst_fall", MDC_Fall, 0);
    repeat (2) @(negedge AXI_Clk);
    AXI_Rstn = 1'b1;
    e4 = cyc + 1;
    push_run(e4, 50, 8);
    push(K_RSTF, e4 + 400);
    wait_cyc(e4 + 30);
    chk("h_default_after_arst", MDC_Clk, 1);
    wait_cyc(e4 + 420);
    chk("events_drained_final", exp_q.size(), 0);
    chk("div_rst_final", Div_Rst, 0);
    chk("active_final", MDC_Active, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
